// File: rtl/block_queue.sv
// Circular block FIFO between the word-to-block assembler and the block device.
// First-word-fall-through output; back-pressure to the assembler via block_in_hold.
module block_queue #(
  parameter int BSIZE     = 128,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [BSIZE-1:0] block_in,
  input  logic             block_in_ready,
  output logic             block_in_hold,
  output logic [BSIZE-1:0] block_out,
  output logic             block_out_valid,
  input  logic             block_read,
  output logic [$clog2(DEPTH):0] level,
  output logic             almost_full,
  output logic             underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
  localparam logic [AW:0] AFULL_L = AFULL_LVL[AW:0];

  // Handshakes: a push happens on an edge where block_in_ready is high and
  // block_in_hold is low; a pop happens on an edge where block_read is high
  // and block_out_valid is high. Neither hold nor valid depends on the
  // same-cycle request, so both sides may keep their request asserted.

  logic [BSIZE-1:0] mem [DEPTH];
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  // Extra pointer MSB separates full from empty; subtraction wraps naturally.
  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == DEPTH_L);
  assign push  = block_in_ready & ~full;
  assign pop   = block_read & ~empty;

  assign block_in_hold   = full;
  assign block_out_valid = ~empty;
  assign almost_full     = (level >= AFULL_L);
  assign block_out       = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      underflow_err <= 1'b0;
    end else if (flush) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (block_read && empty) underflow_err <= 1'b1;
    end
  end

  // Storage is never cleared; only pointers define what is valid.
  always_ff @(posedge clock) begin
    if (reset && !flush && push) mem[wr_ptr[AW-1:0]] <= block_in;
  end

endmodule

// File: tb/tb_block_queue.sv
// Directed self-checking bench for block_queue (DEPTH=4, BSIZE=128).
module tb_block_queue;
  localparam int BSIZE = 128;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic [BSIZE-1:0] block_in;
  logic             block_in_ready;
  logic             block_in_hold;
  logic [BSIZE-1:0] block_out;
  logic             block_out_valid;
  logic             block_read;
  logic [AW:0]      level;
  logic             almost_full;
  logic             underflow_err;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [BSIZE-1:0] exp_q[$];

  block_queue #(.BSIZE(BSIZE), .DEPTH(DEPTH), .AFULL_LVL(DEPTH-1)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .block_in(block_in), .block_in_ready(block_in_ready), .block_in_hold(block_in_hold),
    .block_out(block_out), .block_out_valid(block_out_valid), .block_read(block_read),
    .level(level), .almost_full(almost_full), .underflow_err(underflow_err)
  );

  // clock/reset block
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [BSIZE-1:0] blk(input logic [3:0] tag, input logic [3:0] n);
    blk = {{31{tag}}, n};
  endfunction

  // Inputs change #1 after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [BSIZE-1:0] d, input logic rd, input logic fl);
    block_in_ready = rdy;
    block_in       = d;
    block_read     = rd;
    flush          = fl;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, blk(4'hA, 4'h1), 1'b0, 1'b0);
    tick();
    tick();
    tests_run++;
    if (level !== 3'd0 || block_out_valid !== 1'b0 || block_in_hold !== 1'b0 ||
        block_out !== '0 || underflow_err !== 1'b0 || almost_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: level=%0d valid=%b hold=%b out=%h uf=%b af=%b expected 0,0,0,0,0,0",
               level, block_out_valid, block_in_hold, block_out, underflow_err, almost_full);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tests_run++;
    if (level !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_no_push: level=%0d expected 0", level);
    end
  endtask

  task automatic test_fill();
    logic [AW:0] exp_lvl;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, blk(4'hA, 4'(i)), 1'b0, 1'b0);
      tick();
      exp_lvl = 3'(i);
      tests_run++;
      if (level !== exp_lvl || almost_full !== (i >= 3) || block_in_hold !== (i == 4) ||
          block_out !== blk(4'hA, 4'h1) || block_out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL fill_%0d: level=%0d af=%b hold=%b out=%h expected level=%0d af=%b hold=%b out=%h",
                 i, level, almost_full, block_in_hold, block_out, exp_lvl, (i >= 3), (i == 4), blk(4'hA, 4'h1));
      end
    end
    drive(1'b1, blk(4'hA, 4'h5), 1'b0, 1'b0);
    tick();
    tests_run++;
    if (level !== 3'd4 || block_in_hold !== 1'b1 || block_out !== blk(4'hA, 4'h1)) begin
      tests_failed++;
      $display("FAIL fill_held: level=%0d hold=%b out=%h expected 4,1,%h", level, block_in_hold, block_out, blk(4'hA, 4'h1));
    end
  endtask

  task automatic test_full_push_pop();
    drive(1'b1, blk(4'hA, 4'h5), 1'b1, 1'b0);
    tick();
    tests_run++;
    if (level !== 3'd3 || block_in_hold !== 1'b0 || block_out !== blk(4'hA, 4'h2)) begin
      tests_failed++;
      $display("FAIL full_pushpop: level=%0d hold=%b out=%h expected 3,0,%h", level, block_in_hold, block_out, blk(4'hA, 4'h2));
    end
    drive(1'b1, blk(4'hA, 4'h5), 1'b0, 1'b0);
    tick();
    tests_run++;
    if (level !== 3'd4) begin
      tests_failed++;
      $display("FAIL full_refill: level=%0d expected 4", level);
    end
    for (int i = 2; i <= 5; i++) begin
      tests_run++;
      if (block_out !== blk(4'hA, 4'(i)) || block_out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL drain_%0d: out=%h valid=%b expected %h,1", i, block_out, block_out_valid, blk(4'hA, 4'(i)));
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tests_run++;
    if (level !== 3'd0 || block_out_valid !== 1'b0 || block_out !== '0 || underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_empty: level=%0d valid=%b out=%h uf=%b expected 0,0,0,0", level, block_out_valid, block_out, underflow_err);
    end
  endtask

  task automatic test_stream_wrap();
    for (int i = 1; i <= 2; i++) begin
      drive(1'b1, blk(4'hB, 4'(i)), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (block_out !== blk(4'hB, 4'(i + 1)) || level !== 3'd2) begin
        tests_failed++;
        $display("FAIL wrap_%0d: out=%h level=%0d expected %h,2", i, block_out, level, blk(4'hB, 4'(i + 1)));
      end
      drive(1'b1, blk(4'hB, 4'(i + 3)), 1'b1, 1'b0);
      tick();
    end
    for (int i = 7; i <= 8; i++) begin
      tests_run++;
      if (block_out !== blk(4'hB, 4'(i))) begin
        tests_failed++;
        $display("FAIL wrap_tail_%0d: out=%h expected %h", i, block_out, blk(4'hB, 4'(i)));
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tests_run++;
    if (level !== 3'd0 || underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_end: level=%0d uf=%b expected 0,0", level, underflow_err);
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tests_run++;
    if (underflow_err !== 1'b1 || level !== 3'd0) begin
      tests_failed++;
      $display("FAIL underflow_set: uf=%b level=%0d expected 1,0", underflow_err, level);
    end
    tick();
    tests_run++;
    if (underflow_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow_sticky: uf=%b expected 1", underflow_err);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tests_run++;
    if (underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL underflow_flush: uf=%b expected 0", underflow_err);
    end
    // Push into an empty queue while reading: push lands, read counts as underflow.
    drive(1'b1, blk(4'hC, 4'h1), 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tests_run++;
    if (underflow_err !== 1'b1 || level !== 3'd1 || block_out !== blk(4'hC, 4'h1)) begin
      tests_failed++;
      $display("FAIL empty_pushpop: uf=%b level=%0d out=%h expected 1,1,%h", underflow_err, level, block_out, blk(4'hC, 4'h1));
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, blk(4'hD, 4'(i)), 1'b0, 1'b0);
      tick();
    end
    tests_run++;
    if (level !== 3'd3) begin
      tests_failed++;
      $display("FAIL flush_pre: level=%0d expected 3", level);
    end
    drive(1'b1, blk(4'hD, 4'h4), 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tests_run++;
    if (level !== 3'd0 || block_out_valid !== 1'b0 || block_out !== '0 || underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_clear: level=%0d valid=%b out=%h uf=%b expected 0,0,0,0", level, block_out_valid, block_out, underflow_err);
    end
  endtask

  task automatic test_random_stream();
    int pushed = 0;
    int popped = 0;
    int cycles = 0;
    logic rdy, rd;
    logic [BSIZE-1:0] d;
    exp_q.delete();
    while (popped < 10 && cycles < 300) begin
      rdy = (pushed < 10) && ($urandom_range(0, 3) != 0);
      rd  = (exp_q.size() != 0) && ($urandom_range(0, 2) != 0);
      d   = {$urandom, $urandom, $urandom, $urandom};
      tests_run++;
      if (level !== 3'(exp_q.size()) || block_out_valid !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && block_out !== exp_q[0])) begin
        tests_failed++;
        $display("FAIL random_c%0d: level=%0d valid=%b out=%h expected level=%0d head=%h",
                 cycles, level, block_out_valid, block_out, exp_q.size(),
                 (exp_q.size() != 0) ? exp_q[0] : '0);
      end
      drive(rdy, d, rd, 1'b0);
      if (rd) begin
        void'(exp_q.pop_front());
        popped++;
      end
      if (rdy && (exp_q.size() + (rd ? 1 : 0)) < DEPTH) begin
        exp_q.push_back(d);
        pushed++;
      end
      tick();
      cycles++;
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tests_run++;
    if (popped != 10 || level !== 3'd0 || underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL random_end: popped=%0d level=%0d uf=%b expected 10,0,0", popped, level, underflow_err);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_fill();
    test_full_push_pop();
    test_stream_wrap();
    test_underflow();
    test_flush();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
